instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Synthesisable instruction-fetch sequencer that generates word addresses into inst_mem in place of the fixed-delay address counter.
- Presents each address for DWELL cycles, retires it, and then advances sequentially or by a taken-branch offset taken from the datapath (PCSrc / Immediate).
- Stops on an instruction budget, at the end of memory, or on an out-of-range branch.
- Sits between the test harness/top and inst_mem; drives word_address and a fetch_valid qualifier.

Parameters:
- ADDR_W, 5, width of word_address.
- DEPTH, 32, number of valid instruction words; must be ≤ 2**ADDR_W.
- DWELL, 4, clock cycles each address is held; must be ≥ 1.
- MAX_INSTR, 31, instruction budget; reaching it ends the run.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run from address 0 when in IDLE or DONE.
- halt  in  1  level; freezes sequencing while high.
- branch_taken  in  1  PCSrc from the datapath; sampled on the retire cycle only.
- branch_offset  in  16  signed word offset (Immediate); sampled with branch_taken.
- word_address  out  ADDR_W  current instruction word address.
- fetch_valid  out  1  high while word_address holds a live fetch (RUN state).
- retire  out  1  one-cycle pulse on the last dwell cycle of each instruction.
- instr_count  out  ADDR_W+1  number of retired instructions in this run.
- done  out  1  high in DONE state.
- range_err  out  1  sticky; set when a branch target falls outside [0, DEPTH-1].

Behaviour:
- Reset (async, rst_n=0): state=IDLE, word_address=0, dwell counter=0, instr_count=0; fetch_valid, retire, done and range_err all 0.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE -> RUN on start=1 with halt=0. Sets word_address=0, instr_count=0, range_err=0, dwell=0. fetch_valid rises the next cycle.
- RUN: dwell increments each cycle. When dwell==DWELL-1:
  - retire=1 and instr_count increments.
  - Next address: if branch_taken, addr+1+sext(branch_offset), computed in ADDR_W+17-bit signed arithmetic; otherwise addr+1.
  - dwell resets to 0.
- RUN -> DONE on the retire cycle if any of the following holds:
  - the new instr_count == MAX_INSTR;
  - a sequential next address == DEPTH;
  - a branch target < 0 or ≥ DEPTH. This case also sets range_err=1.
- On RUN -> DONE, word_address holds the last retired address and is not updated.
- RUN -> PAUSE when halt=1. The dwell counter and address freeze, fetch_valid=0 and no retire occurs. PAUSE -> RUN when halt=0, resuming at the frozen dwell value.
- If halt=1 on a would-be retire cycle, halt wins: the retire is deferred until resume.
- DONE: done=1 and fetch_valid=0. start with halt=0 restarts exactly as from IDLE.
- start while in RUN or PAUSE is ignored. start together with halt=1 in IDLE/DONE is ignored.
- branch_taken and branch_offset are ignored on non-retire cycles.
- DWELL=1: retire every cycle in RUN.
- Async reset mid-run: immediate return to the reset values above; no partial retire is counted.

Optional Feature:
- FETCH_WRAP_EN defined: a sequential increment from DEPTH-1 wraps to 0 and the run continues; only MAX_INSTR or an out-of-range branch ends it.
- FETCH_WRAP_EN undefined: reaching DEPTH sequentially ends the run in DONE, as specified above.

Test Plan:
- Defaults, start pulse, no branches -> addresses 0..30, each held 4 cycles; retire pulses 31 times; done=1 with instr_count=31, word_address=30, range_err=0.
- DWELL=1, DEPTH=8, MAX_INSTR=31, wrap off -> addresses 0..7, then DONE with instr_count=8; with FETCH_WRAP_EN -> address sequence 0..7,0..7,… continuing until instr_count=31, ending at word_address=6.
- branch_taken=1, branch_offset=+3 at address 2 -> next address 6; branch_offset=-3 (0xFFFD) at address 6 -> next address 4.
- branch_offset=-10 at address 2 -> DONE, range_err=1, word_address stays 2.
- halt=1 for 7 cycles at dwell=2 of address 5 -> fetch_valid=0 during halt; after release, address 5 retires 2 cycles later with no skipped or double retire.
- rst_n=0 asserted mid-dwell at address 9 -> outputs zero immediately, state IDLE; a new start begins at address 0 with instr_count=0.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// ============================================================================
// Module   : instr_fetch_seq
// Brief    : Instruction-fetch sequencer. Holds each word address for DWELL
//            cycles, retires it, then advances sequentially or by a taken
//            branch offset. Stops on the instruction budget, at the end of
//            memory, or on an out-of-range branch target.
// Options  : FETCH_WRAP_EN - sequential fetch wraps DEPTH-1 -> 0 instead of
//            ending the run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_seq #(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 32,
  parameter int DWELL     = 4,
  parameter int MAX_INSTR = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  output logic [ADDR_W-1:0] word_address,
  output logic              fetch_valid,
  output logic              retire,
  output logic [ADDR_W:0]   instr_count,
  output logic              done,
  output logic              range_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  // Branch target arithmetic width: address plus sign-extended 16-bit offset
  // with enough headroom that neither overflow nor underflow can alias.
  localparam int TW   = ADDR_W + 17;

  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] MAX_C      = (ADDR_W + 1)'(MAX_INSTR);
  localparam logic [TW-1:0]   DEPTH_T    = TW'(DEPTH);

  logic [1:0]        state;
  logic [DW_W-1:0]   dwell;

  logic              retire_now;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W:0]   seq_next;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_end;
  logic [TW-1:0]     br_target;
  logic              br_bad;
  logic [ADDR_W-1:0] next_addr;
  logic              finish;

  // Next-address selection and run-termination decision for the retire cycle
  always_comb begin
    retire_now = (state == S_RUN) && !halt && (dwell == DWELL_LAST);
    count_next = instr_count + (ADDR_W + 1)'(1);
    seq_next   = (ADDR_W + 1)'(word_address) + (ADDR_W + 1)'(1);
`ifdef FETCH_WRAP_EN
    seq_end    = 1'b0;
    seq_addr   = (seq_next == DEPTH_C) ? '0 : seq_next[ADDR_W-1:0];
`else
    seq_end    = (seq_next == DEPTH_C);
    seq_addr   = seq_next[ADDR_W-1:0];
`endif
    // Two's-complement sum; a set MSB means the target went negative.
    br_target  = TW'(word_address) + {{(ADDR_W + 1){branch_offset[15]}}, branch_offset}
                 + TW'(1);
    br_bad     = branch_taken && (br_target[TW-1] || (br_target >= DEPTH_T));
    next_addr  = branch_taken ? br_target[ADDR_W-1:0] : seq_addr;
    finish     = (count_next == MAX_C) || (!branch_taken && seq_end) || br_bad;
  end

  // Sequencer state, dwell counter, address and run statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dwell        <= '0;
      word_address <= '0;
      instr_count  <= '0;
      range_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && !halt) begin
            state        <= S_RUN;
            dwell        <= '0;
            word_address <= '0;
            instr_count  <= '0;
            range_err    <= 1'b0;
          end
        end
        S_RUN: begin
          if (halt) begin
            state <= S_PAUSE;
          end else if (dwell == DWELL_LAST) begin
            dwell       <= '0;
            instr_count <= count_next;
            if (br_bad) begin
              range_err <= 1'b1;
            end
            // On termination the last retired address stays visible.
            if (finish) begin
              state <= S_DONE;
            end else begin
              word_address <= next_addr;
            end
          end else begin
            dwell <= dwell + DW_W'(1);
          end
        end
        S_PAUSE: begin
          if (!halt) begin
            state <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    fetch_valid = (state == S_RUN);
    done        = (state == S_DONE);
    retire      = retire_now;
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
// ============================================================================
// Module   : tb_instr_fetch_seq
// Brief    : Self-checking bench for instr_fetch_seq. Two instances share the
//            stimulus: the default build and a DWELL=1 / DEPTH=8 build.
//            FETCH_WRAP_EN selects the wrap expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_seq;

  localparam int AW   = 5;
  localparam int MAXI = 31;
`ifdef FETCH_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          halt;
  logic          branch_taken;
  logic [15:0]   branch_offset;

  logic [AW-1:0] wa0, wa1;
  logic          fv0, fv1, rt0, rt1, dn0, dn1, re0, re1;
  logic [AW:0]   ic0, ic1;

  instr_fetch_seq u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .word_address(wa0), .fetch_valid(fv0), .retire(rt0),
    .instr_count(ic0), .done(dn0), .range_err(re0)
  );

  instr_fetch_seq #(.ADDR_W(5), .DEPTH(8), .DWELL(1), .MAX_INSTR(31)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .word_address(wa1), .fetch_valid(fv1), .retire(rt1),
    .instr_count(ic1), .done(dn1), .range_err(re1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 running, 2 paused, 3 finished.
  // m_dw counts how many active cycles the current address has been shown.
  int m_st   [2];
  int m_addr [2];
  int m_dw   [2];
  int m_cnt  [2];
  bit m_rerr [2];

  function automatic int pdepth(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  function automatic int pdwell(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_addr[k] = 0; m_dw[k] = 0; m_cnt[k] = 0; m_rerr[k] = 1'b0;
    end
  endfunction

  function automatic bit model_retire(input int k);
    return (m_st[k] == 1) && !halt && (m_dw[k] == pdwell(k) - 1);
  endfunction

  function automatic logic [14:0] model_vec(input int k);
    return {AW'(m_addr[k]), m_st[k] == 1, model_retire(k), (AW + 1)'(m_cnt[k]),
            m_st[k] == 3, m_rerr[k]};
  endfunction

  // Advance the model by one clock using the instruction-level rules
  function automatic void model_step();
    int  nxt;
    bit  stop;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_st[k] = 0; m_addr[k] = 0; m_dw[k] = 0; m_cnt[k] = 0; m_rerr[k] = 1'b0;
      end else if (m_st[k] == 0 || m_st[k] == 3) begin
        if (start && !halt) begin
          m_st[k] = 1; m_addr[k] = 0; m_dw[k] = 0; m_cnt[k] = 0; m_rerr[k] = 1'b0;
        end
      end else if (m_st[k] == 2) begin
        if (!halt) m_st[k] = 1;
      end else if (halt) begin
        m_st[k] = 2;
      end else if (m_dw[k] == pdwell(k) - 1) begin
        stop = 1'b0;
        m_cnt[k]++;
        if (branch_taken) begin
          nxt = m_addr[k] + 1 + int'($signed(branch_offset));
          if (nxt < 0 || nxt >= pdepth(k)) begin
            stop = 1'b1;
            m_rerr[k] = 1'b1;
          end
        end else begin
          nxt = m_addr[k] + 1;
          if (nxt == pdepth(k)) begin
            if (WRAP) nxt = 0;
            else      stop = 1'b1;
          end
        end
        if (m_cnt[k] == MAXI) stop = 1'b1;
        if (stop) m_st[k] = 3;
        else      m_addr[k] = nxt;
        m_dw[k] = 0;
      end else begin
        m_dw[k]++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; branch_offset = '0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance until instance 0 shows address addr with dwell position dw
  task automatic wait_for(input int addr, input int dw, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_st[0] == 1 && m_addr[0] == addr && m_dw[0] == dw) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; halt = 1'b0;
    branch_taken = 1'b0; branch_offset = '0;
    model_reset();
    #1;
    checks++;
    if ({wa0, fv0, rt0, ic0, dn0, re0} !== 15'd0) begin
      failures++;
      $display("FAIL reset_u0 got=%h expected=0", {wa0, fv0, rt0, ic0, dn0, re0});
    end
    checks++;
    if ({wa1, fv1, rt1, ic1, dn1, re1} !== 15'd0) begin
      failures++;
      $display("FAIL reset_u1 got=%h expected=0", {wa1, fv1, rt1, ic1, dn1, re1});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sequential();
    int nret;
    int gap;
    int cyc;
    do_reset();
    kick();
    nret = 0; gap = 0; cyc = 0;
    while (!dn0 && cyc < 400) begin
      gap++;
      checks++;
      if (fv0 !== 1'b1) begin
        failures++;
        $display("FAIL seq_fetch_valid got=%b expected=1 cyc=%0d", fv0, cyc);
      end
      if (rt0) begin
        checks++;
        if (wa0 !== AW'(nret) || gap != 4) begin
          failures++;
          $display("FAIL seq_retire got=addr%0d/gap%0d expected=addr%0d/gap4", wa0, gap, nret);
        end
        nret++;
        gap = 0;
      end
      cyc++;
      tick();
    end
    checks++;
    if ({dn0, ic0, wa0, re0} !== {1'b1, 6'd31, 5'd30, 1'b0} || nret != 31) begin
      failures++;
      $display("FAIL seq_end got=done%b cnt%0d addr%0d err%b ret%0d expected=done1 cnt31 addr30 err0 ret31",
               dn0, ic0, wa0, re0, nret);
    end
    checks++;
    if ({dn1, ic1, wa1, re1} !== {1'b1, (WRAP ? 6'd31 : 6'd8), (WRAP ? 5'd6 : 5'd7), 1'b0}) begin
      failures++;
      $display("FAIL seq_small_end got=done%b cnt%0d addr%0d err%b expected=done1 cnt%0d addr%0d err0",
               dn1, ic1, wa1, re1, WRAP ? 31 : 8, WRAP ? 6 : 7);
    end
  endtask

  task automatic test_branch();
    bit ok;
    do_reset();
    kick();
    wait_for(2, 3, ok);
    checks++;
    if (!ok || rt0 !== 1'b1) begin
      failures++;
      $display("FAIL br_wait2 got=ok%b/retire%b expected=ok1/retire1", ok, rt0);
    end
    branch_taken = 1'b1; branch_offset = 16'd3;
    tick();
    branch_taken = 1'b0; branch_offset = '0;
    checks++;
    if (wa0 !== 5'd6 || ic0 !== 6'd3) begin
      failures++;
      $display("FAIL br_fwd got=addr%0d cnt%0d expected=addr6 cnt3", wa0, ic0);
    end
    wait_for(6, 3, ok);
    branch_taken = 1'b1; branch_offset = 16'hFFFD;
    tick();
    branch_taken = 1'b0; branch_offset = '0;
    checks++;
    if (!ok || wa0 !== 5'd4 || ic0 !== 6'd4) begin
      failures++;
      $display("FAIL br_back got=ok%b addr%0d cnt%0d expected=ok1 addr4 cnt4", ok, wa0, ic0);
    end
  endtask

  task automatic test_branch_range();
    bit ok;
    do_reset();
    kick();
    wait_for(2, 3, ok);
    branch_taken = 1'b1; branch_offset = 16'hFFF6;
    tick();
    branch_taken = 1'b0; branch_offset = '0;
    checks++;
    if (!ok || {dn0, re0, fv0, wa0, ic0} !== {1'b1, 1'b1, 1'b0, 5'd2, 6'd3}) begin
      failures++;
      $display("FAIL br_range got=done%b err%b fv%b addr%0d cnt%0d expected=done1 err1 fv0 addr2 cnt3",
               dn0, re0, fv0, wa0, ic0);
    end
    tick();
    checks++;
    if ({dn0, re0, wa0} !== {1'b1, 1'b1, 5'd2}) begin
      failures++;
      $display("FAIL br_range_hold got=done%b err%b addr%0d expected=done1 err1 addr2", dn0, re0, wa0);
    end
    kick();
    checks++;
    if ({dn0, re0, fv0, wa0, ic0} !== {1'b0, 1'b0, 1'b1, 5'd0, 6'd0}) begin
      failures++;
      $display("FAIL restart got=done%b err%b fv%b addr%0d cnt%0d expected=done0 err0 fv1 addr0 cnt0",
               dn0, re0, fv0, wa0, ic0);
    end
  endtask

  task automatic test_halt();
    bit ok;
    int seen;
    do_reset();
    kick();
    wait_for(5, 2, ok);
    halt = 1'b1;
    #1;
    checks++;
    if (!ok || rt0 !== 1'b0 || ic0 !== 6'd5) begin
      failures++;
      $display("FAIL halt_enter got=ok%b retire%b cnt%0d expected=ok1 retire0 cnt5", ok, rt0, ic0);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({fv0, rt0, wa0} !== {1'b0, 1'b0, 5'd5}) begin
        failures++;
        $display("FAIL halt_hold got=fv%b retire%b addr%0d expected=fv0 retire0 addr5", fv0, rt0, wa0);
      end
      tick();
    end
    halt = 1'b0;
    seen = -1;
    for (int j = 0; j < 6; j++) begin
      #1;
      if (rt0) begin
        seen = j;
        break;
      end
      tick();
    end
    checks++;
    if (seen != 2 || wa0 !== 5'd5) begin
      failures++;
      $display("FAIL halt_resume got=after%0d addr%0d expected=after2 addr5", seen, wa0);
    end
    tick();
    checks++;
    if ({rt0, wa0, ic0} !== {1'b0, 5'd6, 6'd6}) begin
      failures++;
      $display("FAIL halt_single got=retire%b addr%0d cnt%0d expected=retire0 addr6 cnt6", rt0, wa0, ic0);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    kick();
    wait_for(9, 1, ok);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (!ok || {wa0, fv0, rt0, ic0, dn0, re0} !== 15'd0) begin
      failures++;
      $display("FAIL async_rst got=ok%b/%h expected=ok1/0", ok, {wa0, fv0, rt0, ic0, dn0, re0});
    end
    tick();
    rst_n = 1'b1;
    kick();
    checks++;
    if ({fv0, wa0, ic0, dn0} !== {1'b1, 5'd0, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_restart got=fv%b addr%0d cnt%0d done%b expected=fv1 addr0 cnt0 done0",
               fv0, wa0, ic0, dn0);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({wa0, ic0} !== {5'd1, 6'd1}) begin
      failures++;
      $display("FAIL async_first got=addr%0d cnt%0d expected=addr1 cnt1", wa0, ic0);
    end
  endtask

  task automatic test_random();
    logic [14:0] got;
    logic [14:0] exp;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n         = ($urandom % 700 != 0);
      start         = ($urandom % 16 == 0);
      halt          = ($urandom % 8 == 0);
      branch_taken  = ($urandom % 3 == 0);
      branch_offset = ($urandom % 5 == 0) ? 16'($urandom)
                                          : 16'(int'($urandom_range(0, 24)) - 12);
      if (!rst_n) model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
        got = (k == 0) ? {wa0, fv0, rt0, ic0, dn0, re0} : {wa1, fv1, rt1, ic1, dn1, re1};
        exp = model_vec(k);
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL rand_u%0d cyc=%0d got=%h expected=%h", k, n, got, exp);
        end
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_branch_range();
    test_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
